// File: rtl/alu_arbiter_if.sv
// alu_arbiter_if
//   Bundles every signal between the two ALU requesters, the shared
//   combinational ALU, the response consumer and the arbiter.
//   Ports (slave = arbiter side):
//     req0_valid/req1_valid  in   requester i has an operation pending
//     req0_ready/req1_ready  out  requester i is granted this cycle
//     req*_op, req*_src1/2   in   opcode and operands of requester i
//     alu_op, alu_src1/2     out  drive the shared ALU
//     alu_res, alu_zero      in   combinational ALU result / zero flag
//     rsp_valid/rsp_ready    out/in  response handshake
//     rsp_id, rsp_res, rsp_zero  out  held response and its requester
//   The master modport is the environment view (requesters, ALU, consumer).

`ifndef CPU_WIDTH
`define CPU_WIDTH 32
`endif
`ifndef ALU_OP_WIDTH
`define ALU_OP_WIDTH 4
`endif

interface alu_arbiter_if #(
  parameter int DW  = `CPU_WIDTH,
  parameter int OPW = `ALU_OP_WIDTH
);
  logic           req0_valid;
  logic           req0_ready;
  logic [OPW-1:0] req0_op;
  logic [DW-1:0]  req0_src1;
  logic [DW-1:0]  req0_src2;

  logic           req1_valid;
  logic           req1_ready;
  logic [OPW-1:0] req1_op;
  logic [DW-1:0]  req1_src1;
  logic [DW-1:0]  req1_src2;

  logic [OPW-1:0] alu_op;
  logic [DW-1:0]  alu_src1;
  logic [DW-1:0]  alu_src2;
  logic [DW-1:0]  alu_res;
  logic           alu_zero;

  logic           rsp_valid;
  logic           rsp_ready;
  logic           rsp_id;
  logic [DW-1:0]  rsp_res;
  logic           rsp_zero;

  modport slave (
    input  req0_valid, req0_op, req0_src1, req0_src2,
    input  req1_valid, req1_op, req1_src1, req1_src2,
    input  alu_res, alu_zero, rsp_ready,
    output req0_ready, req1_ready,
    output alu_op, alu_src1, alu_src2,
    output rsp_valid, rsp_id, rsp_res, rsp_zero
  );

  modport master (
    output req0_valid, req0_op, req0_src1, req0_src2,
    output req1_valid, req1_op, req1_src1, req1_src2,
    output alu_res, alu_zero, rsp_ready,
    input  req0_ready, req1_ready,
    input  alu_op, alu_src1, alu_src2,
    input  rsp_valid, rsp_id, rsp_res, rsp_zero
  );
endinterface

// File: rtl/alu_arbiter.sv
// alu_arbiter
//   Round-robin arbiter time-sharing one combinational ALU between two
//   requesters. The granted requester's op/operands are steered to the
//   ALU in the same cycle; the ALU result and zero flag are captured in a
//   one-entry response register tagged with the requester id.
//   Ports:
//     clk    in  rising-edge clock
//     rst_n  in  asynchronous active-low reset
//     bus    alu_arbiter_if.slave  requester, ALU and response signals

`ifndef CPU_WIDTH
`define CPU_WIDTH 32
`endif
`ifndef ALU_OP_WIDTH
`define ALU_OP_WIDTH 4
`endif

module alu_arbiter #(
  parameter int DW  = `CPU_WIDTH,
  parameter int OPW = `ALU_OP_WIDTH
) (
  input logic          clk,
  input logic          rst_n,
  alu_arbiter_if.slave bus
);

  logic          rsp_valid_q;
  logic          rsp_id_q;
  logic [DW-1:0] rsp_res_q;
  logic          rsp_zero_q;
  logic          last_grant;

  logic slot_free;
  logic gnt0;
  logic gnt1;

  // The slot can take a new result when empty or being drained this cycle.
  assign slot_free = !rsp_valid_q || bus.rsp_ready;

  // Under contention the requester that did not win last time is granted.
  assign gnt0 = slot_free && bus.req0_valid && (!bus.req1_valid || last_grant);
  assign gnt1 = slot_free && bus.req1_valid && (!bus.req0_valid || !last_grant);

  assign bus.req0_ready = gnt0;
  assign bus.req1_ready = gnt1;

  // Steer the granted requester onto the shared ALU; idle drives zeros.
  always_comb begin
    bus.alu_op   = '0;
    bus.alu_src1 = '0;
    bus.alu_src2 = '0;
    if (gnt0) begin
      bus.alu_op   = bus.req0_op;
      bus.alu_src1 = bus.req0_src1;
      bus.alu_src2 = bus.req0_src2;
    end else if (gnt1) begin
      bus.alu_op   = bus.req1_op;
      bus.alu_src1 = bus.req1_src1;
      bus.alu_src2 = bus.req1_src2;
    end
  end

  // A grant overwrites the slot even while it is being drained, giving
  // back-to-back throughput; a drain without a grant just clears valid.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= 1'b0;
      rsp_res_q   <= '0;
      rsp_zero_q  <= 1'b0;
      last_grant  <= 1'b1;
    end else if (gnt0 || gnt1) begin
      rsp_valid_q <= 1'b1;
      rsp_id_q    <= gnt1;
      rsp_res_q   <= bus.alu_res;
      rsp_zero_q  <= bus.alu_zero;
      last_grant  <= gnt1;
    end else if (bus.rsp_ready) begin
      rsp_valid_q <= 1'b0;
    end
  end

  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_id    = rsp_id_q;
  assign bus.rsp_res   = rsp_res_q;
  assign bus.rsp_zero  = rsp_zero_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter
//   Scoreboard bench for alu_arbiter. A predictor applies the arbitration
//   rules each cycle, checks ready/ALU steering, and queues the expected
//   response of every grant; a monitor compares held responses against
//   the queue. Directed scenarios are followed by randomized traffic.

`ifndef CPU_WIDTH
`define CPU_WIDTH 32
`endif
`ifndef ALU_OP_WIDTH
`define ALU_OP_WIDTH 4
`endif
`ifndef ALU_ADD
`define ALU_ADD 4'd1
`endif
`ifndef ALU_SUB
`define ALU_SUB 4'd2
`endif

module tb_alu_arbiter;

  localparam int DW  = `CPU_WIDTH;
  localparam int OPW = `ALU_OP_WIDTH;
  localparam logic [OPW-1:0] OP_ADD = `ALU_ADD;
  localparam logic [OPW-1:0] OP_SUB = `ALU_SUB;

  typedef struct {
    logic          id;
    logic [DW-1:0] res;
    logic          zero;
  } rsp_t;

  logic clk;
  logic rst_n;

  alu_arbiter_if #(.DW(DW), .OPW(OPW)) bus ();

  alu_arbiter #(.DW(DW), .OPW(OPW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;

  rsp_t exp_q[$];
  logic m_valid;
  logic m_last;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference arithmetic: what an add/sub ALU produces for given inputs.
  function automatic rsp_t refOp(input logic id, input logic [OPW-1:0] op,
                                 input logic [DW-1:0] a, input logic [DW-1:0] b);
    rsp_t r;
    r.id = id;
    if (op == OP_ADD) begin
      r.res = a + b;
      r.zero = (r.res == '0);
    end else if (op == OP_SUB) begin
      r.res = a - b;
      r.zero = (r.res == '0);
    end else begin
      r.res = '0;
      r.zero = 1'b0;
    end
    return r;
  endfunction

  // Shared ALU stand-in driven by the arbiter's steering outputs.
  rsp_t alu_out;
  always_comb alu_out = refOp(1'b0, bus.alu_op, bus.alu_src1, bus.alu_src2);
  assign bus.alu_res  = alu_out.res;
  assign bus.alu_zero = alu_out.zero;

  task automatic checkOutput(input string name, input logic [DW-1:0] act,
                             input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // One cycle of requester/consumer inputs, applied just after the edge.
  task automatic applyStimulus(input logic v0, input logic [OPW-1:0] op0,
                               input logic [DW-1:0] a0, input logic [DW-1:0] b0,
                               input logic v1, input logic [OPW-1:0] op1,
                               input logic [DW-1:0] a1, input logic [DW-1:0] b1,
                               input logic rr);
    bus.req0_valid = v0; bus.req0_op = op0; bus.req0_src1 = a0; bus.req0_src2 = b0;
    bus.req1_valid = v1; bus.req1_op = op1; bus.req1_src1 = a1; bus.req1_src2 = b1;
    bus.rsp_ready  = rr;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++)
      applyStimulus(1'b0, '0, '0, '0, 1'b0, '0, '0, '0, 1'b1);
  endtask

  // Asserts reset between edges, checks the asynchronous clear, releases
  // just after the next rising edge.
  task automatic doReset();
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("reset_rsp_valid", 32'(bus.rsp_valid), '0);
    checkOutput("reset_rsp_id",    32'(bus.rsp_id),    '0);
    checkOutput("reset_rsp_res",   bus.rsp_res,        '0);
    checkOutput("reset_rsp_zero",  32'(bus.rsp_zero),  '0);
    exp_q.delete();
    m_valid = 1'b0;
    m_last  = 1'b1;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  // Predictor: arbitration rules applied to the current inputs.
  always @(negedge clk) begin
    if (rst_n) begin
      logic slot, grant, gid;
      logic [OPW-1:0] e_op;
      logic [DW-1:0]  e_a, e_b;
      slot  = !m_valid || bus.rsp_ready;
      grant = 1'b0;
      gid   = 1'b0;
      if (slot) begin
        if (bus.req0_valid && bus.req1_valid) begin
          grant = 1'b1; gid = !m_last;
        end else if (bus.req0_valid) begin
          grant = 1'b1; gid = 1'b0;
        end else if (bus.req1_valid) begin
          grant = 1'b1; gid = 1'b1;
        end
      end
      e_op = '0; e_a = '0; e_b = '0;
      if (grant && !gid) begin
        e_op = bus.req0_op; e_a = bus.req0_src1; e_b = bus.req0_src2;
      end else if (grant) begin
        e_op = bus.req1_op; e_a = bus.req1_src1; e_b = bus.req1_src2;
      end
      checkOutput("rsp_valid",  32'(bus.rsp_valid),  32'(m_valid));
      checkOutput("req0_ready", 32'(bus.req0_ready), 32'(grant && !gid));
      checkOutput("req1_ready", 32'(bus.req1_ready), 32'(grant && gid));
      checkOutput("alu_op",     32'(bus.alu_op),     32'(e_op));
      checkOutput("alu_src1",   bus.alu_src1,        e_a);
      checkOutput("alu_src2",   bus.alu_src2,        e_b);
      if (grant) begin
        exp_q.push_back(refOp(gid, e_op, e_a, e_b));
        m_valid = 1'b1;
        m_last  = gid;
      end else if (bus.rsp_ready) begin
        m_valid = 1'b0;
      end
    end
  end

  // Monitor: a held response must match the oldest expected result, and
  // is retired when the consumer accepts it.
  always @(negedge clk) begin
    #1;
    if (rst_n && bus.rsp_valid) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL rsp_unexpected: got id=%0d res=%0h expected none at %0t",
                 bus.rsp_id, bus.rsp_res, $time);
      end else begin
        checkOutput("rsp_id",   32'(bus.rsp_id),   32'(exp_q[0].id));
        checkOutput("rsp_res",  bus.rsp_res,       exp_q[0].res);
        checkOutput("rsp_zero", 32'(bus.rsp_zero), 32'(exp_q[0].zero));
        if (bus.rsp_ready) void'(exp_q.pop_front());
      end
    end
  end

  // Randomized requester behaviour honouring stable-until-handshake.
  task automatic randomPhase(input int n);
    logic hs0, hs1;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      hs0 = bus.req0_valid && bus.req0_ready;
      hs1 = bus.req1_valid && bus.req1_ready;
      @(posedge clk);
      #1;
      if (!bus.req0_valid || hs0) begin
        bus.req0_valid = ($urandom_range(0, 2) != 0);
        bus.req0_op    = ($urandom_range(0, 5) == 0) ? OPW'($urandom) :
                         ($urandom_range(0, 1) != 0) ? OP_ADD : OP_SUB;
        bus.req0_src1  = DW'($urandom_range(0, 3) == 0 ? $urandom_range(0, 3) : $urandom);
        bus.req0_src2  = DW'($urandom_range(0, 3) == 0 ? $urandom_range(0, 3) : $urandom);
      end
      if (!bus.req1_valid || hs1) begin
        bus.req1_valid = ($urandom_range(0, 2) != 0);
        bus.req1_op    = ($urandom_range(0, 5) == 0) ? OPW'($urandom) :
                         ($urandom_range(0, 1) != 0) ? OP_ADD : OP_SUB;
        bus.req1_src1  = DW'($urandom_range(0, 3) == 0 ? $urandom_range(0, 3) : $urandom);
        bus.req1_src2  = DW'($urandom_range(0, 3) == 0 ? $urandom_range(0, 3) : $urandom);
      end
      bus.rsp_ready = ($urandom_range(0, 3) != 0);
    end
  endtask

  initial begin
    rst_n = 1'b1;
    m_valid = 1'b0;
    m_last  = 1'b1;
    bus.req0_valid = 1'b0; bus.req0_op = '0; bus.req0_src1 = '0; bus.req0_src2 = '0;
    bus.req1_valid = 1'b0; bus.req1_op = '0; bus.req1_src1 = '0; bus.req1_src2 = '0;
    bus.rsp_ready  = 1'b1;
    @(posedge clk);
    #1;
    doReset();

    $display("[TB] single requests and wrap");
    applyStimulus(1'b1, OP_ADD, 32'd5, 32'd3, 1'b0, '0, '0, '0, 1'b1);
    idle(1);
    applyStimulus(1'b0, '0, '0, '0, 1'b1, OP_SUB, 32'd7, 32'd7, 1'b1);
    applyStimulus(1'b0, '0, '0, '0, 1'b1, OP_SUB, 32'd0, 32'd1, 1'b1);
    idle(2);

    $display("[TB] contention after reset");
    doReset();
    for (int i = 0; i < 4; i++)
      applyStimulus(1'b1, OP_ADD, 32'd1, 32'd1, 1'b1, OP_ADD, 32'd2, 32'd2, 1'b1);
    idle(2);

    $display("[TB] backpressure hold");
    applyStimulus(1'b1, OP_ADD, 32'd9, 32'd1, 1'b0, '0, '0, '0, 1'b0);
    for (int i = 0; i < 3; i++)
      applyStimulus(1'b1, OP_ADD, 32'd3, 32'd4, 1'b0, '0, '0, '0, 1'b0);
    applyStimulus(1'b1, OP_ADD, 32'd3, 32'd4, 1'b0, '0, '0, '0, 1'b1);
    idle(2);

    $display("[TB] reset mid-stream");
    applyStimulus(1'b1, OP_SUB, 32'd20, 32'd4, 1'b0, '0, '0, '0, 1'b0);
    bus.req0_valid = 1'b0;
    doReset();
    applyStimulus(1'b1, OP_ADD, 32'd10, 32'd10, 1'b1, OP_SUB, 32'd1, 32'd2, 1'b1);
    applyStimulus(1'b0, '0, '0, '0, 1'b1, OP_SUB, 32'd1, 32'd2, 1'b1);
    idle(3);

    $display("[TB] unknown opcode");
    applyStimulus(1'b1, 4'hF, 32'd6, 32'd6, 1'b0, '0, '0, '0, 1'b1);
    idle(2);

    $display("[TB] random traffic");
    randomPhase(400);
    idle(4);
    checkOutput("queue_empty", 32'(exp_q.size()), '0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_arbiter.md
# alu_arbiter

Two-requester round-robin arbiter that time-shares the single combinational integer ALU (add/sub, zero flag) of the RV-seed core. It drives the shared ALU's op and operand inputs from the granted requester and captures the ALU result and zero flag into a one-entry response register. The response is returned with a valid/ready handshake and tagged with the requester id. It sits between the execute-side users of the ALU (for example the main execute path and a branch/address helper) and the ALU instance.

## Interface
- DW, default `CPU_WIDTH (32): operand/result width.
- OPW, default `ALU_OP_WIDTH: ALU opcode width; encodings come from rvseed_defines.v (`ALU_ADD, `ALU_SUB).
- clk  in  1  single clock; all state updates on its rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- req0_valid / req1_valid  in  1  requester i has an operation pending.
- req0_ready / req1_ready  out  1  requester i is granted this cycle; handshake = valid & ready.
- req0_op / req1_op  in  OPW  ALU opcode for requester i.
- req0_src1, req0_src2 / req1_src1, req1_src2  in  DW  operands for requester i.
- alu_op  out  OPW  to the shared ALU.
- alu_src1, alu_src2  out  DW  to the shared ALU.
- alu_res  in  DW  combinational result from the shared ALU.
- alu_zero  in  1  combinational zero flag from the shared ALU.
- rsp_valid  out  1  response register holds a result.
- rsp_ready  in  1  consumer accepts the response.
- rsp_id  out  1  requester that issued the held result (0 or 1).
- rsp_res  out  DW  held ALU result.
- rsp_zero  out  1  held zero flag.

## Operation
- State: response slot (rsp_valid, rsp_id, rsp_res, rsp_zero) and last_grant (1 bit).
- slot_free = !rsp_valid | rsp_ready. A grant is issued only when slot_free is high.
- Grant selection is combinational in each cycle with slot_free high:
  - Only req0_valid is high: grant 0.
  - Only req1_valid is high: grant 1.
  - Both are high: grant !last_grant, which is round-robin.
  - Neither is high: no grant.
- At most one of req0_ready/req1_ready is high in any cycle. readyN is never high without reqN_valid.
- While a grant is active, alu_op/src1/src2 equal the granted requester's op/src1/src2. With no grant, they are driven to all-zero.
- On a granted handshake, at the next edge:
  - rsp_res ← alu_res, rsp_zero ← alu_zero, rsp_id ← granted id.
  - rsp_valid ← 1 and last_grant ← granted id.
- On rsp_valid & rsp_ready with no new grant, rsp_valid ← 0. The data fields hold their last values.
- Drain and new grant may occur in the same cycle. The slot is overwritten, rsp_valid stays 1, and there is no bubble.
- Requester rules:
  - valid must not depend combinationally on ready.
  - Once asserted, valid, op and operands stay stable until the handshake.
  - The arbiter does not check these rules.
- Arithmetic is whatever the ALU returns. The arbiter does not modify or width-extend data. Add/sub wrap modulo 2^DW.
- Opcodes other than ADD/SUB are still granted. The result is whatever the ALU outputs (0, zero=0).

## Timing
- Reset (rst_n low, asynchronous) values:
  - rsp_valid=0, rsp_id=0, rsp_res=0, rsp_zero=0.
  - last_grant=1, so req0 wins the first contention.
  - Combinational outputs follow the rules above: readyN=0 only if valid is low; alu_* are 0 when idle.
- Reset mid-operation: a held response is dropped, and no handshake completes in the reset cycle. Deassertion of reset is synchronous to clk by the surrounding reset logic.
- req→ready latency: 0 cycles, combinational in the same cycle as valid when slot_free is high.
- Handshake→rsp_valid latency: 1 cycle.
- Throughput: 1 operation/cycle while rsp_ready=1.
- Backpressure: while rsp_valid=1 and rsp_ready=0, both ready outputs are 0, and rsp_* are stable.
- Fairness: with both requesters continuously valid and rsp_ready=1, grants alternate strictly. No requester waits more than 1 grant cycle behind the other.
- Only the clk→ready→alu→alu_res path is combinational. It is a single pass through the ALU; the response register breaks it.

## Test plan
- req0 ADD src1=5, src2=3, rsp_ready=1 → req0_ready=1 in the same cycle; next cycle rsp_valid=1, rsp_id=0, rsp_res=8, rsp_zero=0.
- req1 SUB 7−7 → rsp_id=1, rsp_res=0, rsp_zero=1. Then req1 SUB 0−1 → rsp_res=0xFFFFFFFF, rsp_zero=0 (wrap).
- After reset, both requesters valid for 4 cycles with rsp_ready=1 (req0 ADD 1+1, req1 ADD 2+2) → rsp_id sequence 0,1,0,1 and rsp_res 2,4,2,4; never two readys in one cycle.
- Response held with rsp_ready=0 for 3 cycles while req0 is valid:
  - During the hold, req0_ready=0 and rsp_res/rsp_id are stable.
  - In the cycle rsp_ready rises, req0_ready=1 (same-cycle drain+grant).
  - In the next cycle rsp_valid stays 1 with req0's result.
- Assert rst_n=0 mid-stream with rsp_valid=1 → rsp_valid=0 immediately (asynchronous), and rsp_* are zero. After release, simultaneous requests grant req0 first.
- Idle (no valid) → alu_op, alu_src1, alu_src2 all 0; both readys 0; rsp_valid clears after one accepted drain.
